cmd_playback_buffer: RTL and testbench

//  Host-loaded command playback table, the read-side counterpart of the data collection buffer.

---
 rtl/cmd_playback_buffer.sv | 139 +++++++++++++
 tb/tb_cmd_playback_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_playback_buffer.sv
// Host-loaded command table replayed one entry per control-loop tick as a one-cycle strobe.
// RAM port A fetches the next entry for playback, port B serves register readback.
module cmd_playback_buffer #(
    parameter int unsigned AW        = 10,
    parameter logic [3:0]  TBL_SPACE = 4'h8,
    parameter logic [15:0] CTRL_ADDR = 16'h0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    output logic        cmd_valid,
    output logic [3:0]  cmd_chan,
    output logic [15:0] cmd_data,
    output logic        running,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StFetch, StArmed} state_e;

    state_e        state_q;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] last_q;
    logic          loop_q;
    logic          pending_q;
    logic [31:0]   entry_q;
    logic [31:0]   ram_b_q;
    logic [31:0]   status_q;
    logic          sel_ctrl_q;

    logic tbl_we;
    logic ctrl_we;
    logic unused_entry;

    assign tbl_we       = reg_wen && (reg_waddr[15:12] == TBL_SPACE);
    assign ctrl_we      = reg_wen && (reg_waddr == CTRL_ADDR);
    assign running      = (state_q != StIdle);
    assign unused_entry = ^{entry_q[31], entry_q[29:20]};

    // Non-blocking reads give read-first behaviour on both ports; contents survive reset.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem[reg_waddr[AW-1:0]] <= reg_wdata;
        end
        if (state_q == StFetch) begin
            entry_q <= mem[rd_addr_q];
        end
        ram_b_q <= mem[reg_raddr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_ctrl_q <= 1'b0;
            status_q   <= 32'h0;
        end else begin
            sel_ctrl_q <= (reg_raddr == CTRL_ADDR);
            status_q   <= {running, loop_q, done, overrun, {(28-AW){1'b0}}, rd_addr_q};
        end
    end

    assign reg_rdata = sel_ctrl_q ? status_q : ram_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_addr_q <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            pending_q <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_chan  <= 4'h0;
            cmd_data  <= 16'h0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            // Any control write overrides the playback sequencing for this cycle.
            if (ctrl_we) begin
                if (reg_wdata[31]) begin
                    rd_addr_q <= '0;
                    done      <= 1'b0;
                    overrun   <= 1'b0;
                    pending_q <= 1'b0;
                    loop_q    <= reg_wdata[30];
                    last_q    <= reg_wdata[AW-1:0];
                    state_q   <= StFetch;
                end else begin
                    state_q <= StIdle;
                end
            end else begin
                case (state_q)
                    StFetch: begin
                        state_q <= StArmed;
                        if (tick) begin
                            if (pending_q) begin
                                overrun <= 1'b1;
                            end
                            pending_q <= 1'b1;
                        end
                    end
                    StArmed: begin
                        if (tick || pending_q) begin
                            if (tick && pending_q) begin
                                overrun <= 1'b1;
                            end
                            pending_q <= 1'b0;
                            // Skip entries consume the tick but leave the last command on the outputs.
                            if (!entry_q[30]) begin
                                cmd_valid <= 1'b1;
                                cmd_chan  <= entry_q[19:16];
                                cmd_data  <= entry_q[15:0];
                            end
                            if (rd_addr_q == last_q) begin
                                if (loop_q) begin
                                    rd_addr_q <= '0;
                                    state_q   <= StFetch;
                                end else begin
                                    done    <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end else begin
                                rd_addr_q <= rd_addr_q + 1'b1;
                                state_q   <= StFetch;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_playback_buffer.sv
// Bench for cmd_playback_buffer: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural playback model.
module tb_cmd_playback_buffer;

    localparam logic [15:0] CTRL = 16'h0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [15:0] reg_raddr;
    logic [31:0] reg_rdata;
    logic        cmd_valid;
    logic [3:0]  cmd_chan;
    logic [15:0] cmd_data;
    logic        running;
    logic        done;
    logic        overrun;

    always #5 clk = ~clk;

    cmd_playback_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .reg_wen   (reg_wen),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .cmd_valid (cmd_valid),
        .cmd_chan  (cmd_chan),
        .cmd_data  (cmd_data),
        .running   (running),
        .done      (done),
        .overrun   (overrun)
    );

    int total = 0;
    int bad   = 0;

    // Model: table contents, playback position and the flags as the host would see them.
    logic [31:0] m_mem   [1024];
    bit          m_known [1024];
    bit          m_active, m_loop, m_done, m_ovr, m_pend, m_fetch_next;
    int          m_idx, m_last;
    logic [31:0] m_entry;
    bit          e_valid;
    logic [3:0]  e_chan;
    logic [15:0] e_data;
    logic [31:0] e_rdata;
    bit          e_rchk;
    logic [19:0] strobes [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tblw, ctl;
        int ra;
        e_valid = 1'b0;
        if (reset) begin
            m_active = 0; m_loop = 0; m_done = 0; m_ovr = 0; m_pend = 0; m_fetch_next = 0;
            m_idx = 0; m_last = 0; e_chan = 4'h0; e_data = 16'h0; e_rchk = 0;
            return;
        end
        tblw = reg_wen && (reg_waddr[15:12] == 4'h8);
        ctl  = reg_wen && (reg_waddr == CTRL);
        ra   = int'(reg_raddr[9:0]);
        if (reg_raddr == CTRL) begin
            e_rdata = {m_active, m_loop, m_done, m_ovr, 18'b0, 10'(m_idx)};
            e_rchk  = 1;
        end else begin
            e_rdata = m_mem[ra];
            e_rchk  = m_known[ra] && !(tblw && reg_waddr[9:0] == reg_raddr[9:0]);
        end
        if (ctl) begin
            if (reg_wdata[31]) begin
                m_active = 1; m_idx = 0; m_done = 0; m_ovr = 0; m_pend = 0;
                m_loop = reg_wdata[30]; m_last = int'(reg_wdata[9:0]); m_fetch_next = 1;
            end else begin
                m_active = 0;
            end
        end else if (m_active) begin
            if (m_fetch_next) begin
                m_entry = m_mem[m_idx];
                m_fetch_next = 0;
                if (tick) begin
                    if (m_pend) m_ovr = 1;
                    m_pend = 1;
                end
            end else if (tick || m_pend) begin
                if (tick && m_pend) m_ovr = 1;
                m_pend = 0;
                if (!m_entry[30]) begin
                    e_valid = 1;
                    e_chan  = m_entry[19:16];
                    e_data  = m_entry[15:0];
                end
                if (m_idx == m_last) begin
                    if (m_loop) begin
                        m_idx = 0;
                        m_fetch_next = 1;
                    end else begin
                        m_done = 1;
                        m_active = 0;
                    end
                end else begin
                    m_idx++;
                    m_fetch_next = 1;
                end
            end
        end
        if (tblw) begin
            m_mem[reg_waddr[9:0]]   = reg_wdata;
            m_known[reg_waddr[9:0]] = 1;
        end
    endtask

    task automatic compare();
        check("cmd_valid", 32'(cmd_valid), 32'(e_valid));
        check("cmd_chan", 32'(cmd_chan), 32'(e_chan));
        check("cmd_data", 32'(cmd_data), 32'(e_data));
        check("running", 32'(running), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (e_rchk) check("reg_rdata", reg_rdata, e_rdata);
        if (cmd_valid) strobes.push_back({cmd_chan, cmd_data});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        tick    = 1'b0;
        reg_wen = 1'b0;
        reset   = 1'b0;
        compare();
    endtask

    task automatic wr(logic [15:0] a, logic [31:0] d);
        reg_wen   = 1'b1;
        reg_waddr = a;
        reg_wdata = d;
        step();
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic tk();
        tick = 1'b1;
        step();
        idle(2);
    endtask

    initial begin
        logic [3:0]  chs [5];
        logic [31:0] d;
        int          r;
        chs = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
        reset = 1'b1; tick = 1'b0; reg_wen = 1'b0;
        reg_waddr = 16'h0; reg_wdata = 32'h0; reg_raddr = 16'h8000;
        step();
        idle(2);

        // 1: single run of three entries
        wr(16'h8000, 32'h0001_0100);
        wr(16'h8001, 32'h0002_0200);
        wr(16'h8002, 32'h0003_0300);
        strobes.delete();
        wr(CTRL, 32'h8000_0002);
        idle(1);
        repeat (4) tk();
        check("t1 count", 32'(strobes.size()), 32'd3);
        check("t1 s0", 32'(strobes[0]), 32'h1_0100);
        check("t1 s1", 32'(strobes[1]), 32'h2_0200);
        check("t1 s2", 32'(strobes[2]), 32'h3_0300);
        check("t1 done", 32'(done), 32'd1);
        check("t1 running", 32'(running), 32'd0);

        // 2: looping over entries 0..1
        strobes.delete();
        wr(CTRL, 32'hC000_0001);
        idle(1);
        repeat (5) tk();
        check("t2 count", 32'(strobes.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t2 chan", 32'(strobes[i][19:16]), 32'(chs[i]));
        check("t2 done", 32'(done), 32'd0);
        check("t2 running", 32'(running), 32'd1);

        // 3: tick during FETCH is held pending, a second one overruns
        wr(CTRL, 32'h0);
        idle(1);
        wr(CTRL, 32'h8000_0002);
        tick = 1'b1; step();
        tick = 1'b1; step();
        check("t3 strobe", 32'(cmd_valid), 32'd1);
        check("t3 chan", 32'(cmd_chan), 32'd1);
        check("t3 overrun", 32'(overrun), 32'd1);

        // 4: skip entry consumes a tick silently
        wr(CTRL, 32'h0);
        wr(16'h8001, 32'h4002_0200);
        strobes.delete();
        wr(CTRL, 32'h8000_0002);
        idle(1);
        repeat (3) tk();
        check("t4 count", 32'(strobes.size()), 32'd2);
        check("t4 s0", 32'(strobes[0]), 32'h1_0100);
        check("t4 s1", 32'(strobes[1]), 32'h3_0300);

        // 5: stop mid-run, then restart from entry 0
        wr(16'h8001, 32'h0002_0200);
        wr(CTRL, 32'h8000_0002);
        idle(1);
        tk();
        wr(CTRL, 32'h0);
        check("t5 stopped", 32'(running), 32'd0);
        strobes.delete();
        repeat (3) tk();
        check("t5 silent", 32'(strobes.size()), 32'd0);
        wr(CTRL, 32'h8000_0002);
        idle(1);
        tk();
        check("t5 restart n", 32'(strobes.size()), 32'd1);
        check("t5 restart s0", 32'(strobes[0]), 32'h1_0100);

        // 6: reset while ARMED, RAM survives
        reset = 1'b1;
        step();
        check("t6 valid", 32'(cmd_valid), 32'd0);
        check("t6 chan", 32'(cmd_chan), 32'd0);
        check("t6 data", 32'(cmd_data), 32'd0);
        check("t6 running", 32'(running), 32'd0);
        reg_raddr = 16'h8001;
        step();
        check("t6 ram1", reg_rdata, 32'h0002_0200);

        // Random traffic over a 16-entry window
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            d[30] = ($urandom_range(3) == 0);
            wr(16'h8000 | 16'(i), d);
        end
        wr(CTRL, 32'hC000_000F);
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(99));
            tick = ($urandom_range(2) == 0);
            if (r < 3) begin
                d = $urandom;
                d[31] = ($urandom_range(4) != 0);
                d[9:0] = 10'($urandom_range(15));
                reg_wen = 1'b1; reg_waddr = CTRL; reg_wdata = d;
            end else if (r < 12) begin
                d = $urandom;
                d[30] = ($urandom_range(3) == 0);
                reg_wen = 1'b1;
                reg_waddr = ((r < 10) ? 16'h8000 : 16'h7000) | 16'($urandom_range(15));
                reg_wdata = d;
            end else if ($urandom_range(499) == 0) begin
                reset = 1'b1;
            end
            reg_raddr = ($urandom_range(4) == 0) ? CTRL : (16'h8000 | 16'($urandom_range(15)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
